wb_unit: RTL and testbench
==========================

# wb_unit

Writeback unit driving the single write port of the general register file. It merges single-cycle ALU results with variable-latency load results into one registered write stream, with ALU results taking priority and load results buffered. It drops writes to register 0 and raises a read-after-write stall to decode while a load result is still queued. It sits between the execute/memory stages and the register file.

## Interface

- DEPTH, 2, load-result buffer entries; power of two, at least 2
- AW, 5, register address width; equals log2(`RF_REG_NUM)
- iClk  in  1  clock, rising edge
- iReset_n  in  1  asynchronous active-low reset
- iAluValid  in  1  ALU result present this cycle; no backpressure
- iAluReg  in  AW  ALU destination register
- iAluData  in  `DATA_W  ALU result
- iLdValid  in  1  load result offered
- oLdReady  out  1  load result accepted when iLdValid && oLdReady
- iLdReg  in  AW  load destination register
- iLdData  in  `DATA_W  load data
- iChkReg1, iChkReg2  in  AW each  decode source registers checked for hazard
- oStall  out  1  a source register has a write still queued
- oRegWr  out  1  register file write enable
- oWrReg  out  AW  register file write address
- oWrData  out  `DATA_W  register file write data
- oPending  out  log2(DEPTH)+1  valid entries in the load buffer

## Operation

- Load buffer: FIFO of {valid, reg, data}, DEPTH entries, with read/write pointers that wrap modulo DEPTH and an occupancy counter.
- Push: iLdValid && oLdReady. Loads with iLdReg==0 are accepted but not stored.
- oLdReady = (count < DEPTH). It depends on the registered count only, so a pop in the same cycle does not free space.
- Each cycle, exactly one write source is selected:
  - if iAluValid && iAluReg!=0: ALU wins;
  - otherwise, if the buffer is non-empty: pop the head.
- A popped entry with valid==0 produces no write. This consumes one cycle.
- ALU kill rule: when the ALU writes register R, every buffered entry with reg==R is cleared to valid=0 in that cycle, so the younger ALU value is never overwritten.
- A load pushed in the same cycle as an ALU write to the same register is not killed. The load is younger.
- Output register: oRegWr, oWrReg and oWrData load the selected source at each edge. When nothing is selected, oRegWr is 0 and the address/data hold their values.
- oStall (combinational) is asserted when, for either iChkReg1 or iChkReg2:
  - the register is non-zero, and
  - it matches a buffered entry with valid==1, or it matches oWrReg while oRegWr==1.
- oPending = count.

## Timing

- Reset (async assert, sync release): count 0, pointers 0, all entry valids 0, oRegWr 0, oWrReg 0, oWrData 0. This gives oLdReady 1, oStall 0, oPending 0.
- ALU latency: iAluValid at edge N produces oRegWr=1 with its data during cycle N+1.
- Load latency, minimum: accepted at edge N, popped at edge N+1 if no ALU write, so oRegWr during N+2. Each ALU cycle adds one cycle of delay.
- Full: oLdReady=0. iLdValid held with stable iLdReg/iLdData until accepted (standard valid/ready rule).
- Empty with no ALU write: oRegWr=0 on the next cycle.
- Simultaneous push and pop: count unchanged. Pointer wrap is exercised at DEPTH boundaries.
- Reset mid-operation: buffered loads are discarded and no write is emitted after reset asserts.

## Structure

- Shared defines include: `DATA_W, `RF_REG_NUM, `RF_ADDR_W (=AW default). No new global constants.
- One sub-module: wb_fifo, holding the storage, pointers and count. It exposes per-entry reg/valid for the hazard compare and a kill-by-register input.
- wb_unit top contains source selection, the output register and the stall logic.

## Test plan

- Reset then iAluValid=1, iAluReg=3, iAluData=0x1234 for one cycle: next cycle oRegWr=1, oWrReg=3, oWrData=0x1234; cycle after, oRegWr=0.
- Load reg 7 = 0xAA accepted with ALU idle: oPending=1 for one cycle, then oRegWr=1, oWrReg=7, oWrData=0xAA two cycles after accept. While queued, iChkReg1=7 gives oStall=1; iChkReg1=0 gives oStall=0.
- ALU busy every cycle while 3 loads are offered (DEPTH=2): two accepted, then oLdReady=0, oPending=2. When the ALU stops, the loads drain in order, oLdReady returns to 1, and the third load completes.
- Load reg 5 = 0x11 queued, then ALU writes reg 5 = 0x22: writes observed are 0x22 only. The killed entry pops with oRegWr=0 and the final reg 5 value is 0x22.
- ALU write to reg 0 and load to reg 0: oRegWr never asserts, oPending stays 0.
- Two loads queued, iReset_n pulsed low mid-drain: outputs are immediately 0, oPending=0, and no further writes after release.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// wb_unit_pkg: shared types and constants for the writeback unit.
// The widths come from the codebase-wide defines; the guarded defaults
// below only apply when this slice is compiled without the shared
// define header.
// Contents: DATA_W / RF_REG_NUM / RF_ADDR_W localparams, the write-source
// enum and a register-hazard compare helper.

`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef RF_REG_NUM
`define RF_REG_NUM 32
`endif
`ifndef RF_ADDR_W
`define RF_ADDR_W 5
`endif

package wb_unit_pkg;

  localparam int DATA_W     = `DATA_W;
  localparam int RF_REG_NUM = `RF_REG_NUM;
  localparam int RF_ADDR_W  = `RF_ADDR_W;

  // Which source drives the register file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2
  } wbSrc_e;

  // True when a decode source register is a real (non-zero) register that
  // matches a candidate in-flight destination. Register 0 never hazards.
  function automatic logic regHit(input logic [RF_ADDR_W-1:0] chkReg,
                                  input logic [RF_ADDR_W-1:0] candReg);
    return (chkReg != {RF_ADDR_W{1'b0}}) && (chkReg == candReg);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: load-result buffer for the writeback unit.
// Circular FIFO of {valid, reg, data} entries with wrapping pointers and an
// occupancy counter. An entry's valid bit is cleared when it is popped or
// when a younger ALU write to the same register kills it, so oEntValid only
// ever marks writes that are still going to happen.
// Ports:
//   iClk, iReset_n         clock, async active-low reset
//   iPush/iPushReg/Data    store a new entry (ignored when full)
//   iPop                   retire the head entry (ignored when empty)
//   iKill/iKillReg         clear valid on every entry targeting iKillReg
//   oFull, oEmpty, oCount  occupancy
//   oHeadValid/Reg/Data    head entry contents
//   oEntValid, oEntReg     per-entry valid/reg for hazard compare

module wb_fifo
  import wb_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = RF_ADDR_W
) (
  input  logic                          iClk,
  input  logic                          iReset_n,
  input  logic                          iPush,
  input  logic [AW-1:0]                 iPushReg,
  input  logic [DATA_W-1:0]             iPushData,
  input  logic                          iPop,
  input  logic                          iKill,
  input  logic [AW-1:0]                 iKillReg,
  output logic                          oFull,
  output logic                          oEmpty,
  output logic [$clog2(DEPTH):0]        oCount,
  output logic                          oHeadValid,
  output logic [AW-1:0]                 oHeadReg,
  output logic [DATA_W-1:0]             oHeadData,
  output logic [DEPTH-1:0]              oEntValid,
  output logic [DEPTH-1:0][AW-1:0]      oEntReg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]           wrPtr_r;
  logic [PW-1:0]           rdPtr_r;
  logic [CW-1:0]           count_r;
  logic [DEPTH-1:0]        entValid_r;
  logic [DEPTH-1:0][AW-1:0] entReg_r;
  logic [DATA_W-1:0]       entData_r [DEPTH];

  logic doPush_s;
  logic doPop_s;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign doPush_s = iPush && !oFull;
  assign doPop_s  = iPop && !oEmpty;

  assign oFull      = (count_r == FULL_CNT);
  assign oEmpty     = (count_r == {CW{1'b0}});
  assign oCount     = count_r;
  assign oHeadValid = entValid_r[rdPtr_r];
  assign oHeadReg   = entReg_r[rdPtr_r];
  assign oHeadData  = entData_r[rdPtr_r];
  assign oEntValid  = entValid_r;
  assign oEntReg    = entReg_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^PW).
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wrPtr_r <= {PW{1'b0}};
      rdPtr_r <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (doPush_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: a fresh push always lands valid (it is younger than any
  // same-cycle ALU write); otherwise kill and pop both retire the entry.
  // Push and pop never target the same slot, since that needs count==0
  // (no pop) or count==DEPTH (no push).
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entValid_r[i] <= 1'b0;
        entReg_r[i]   <= {AW{1'b0}};
        entData_r[i]  <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (doPush_s && (wrPtr_r == PW'(i))) begin
          entValid_r[i] <= 1'b1;
          entReg_r[i]   <= iPushReg;
          entData_r[i]  <= iPushData;
        end else if (iKill && entValid_r[i] && (entReg_r[i] == iKillReg)) begin
          entValid_r[i] <= 1'b0;
        end else if (doPop_s && (rdPtr_r == PW'(i))) begin
          entValid_r[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback unit driving the single register-file write port.
// Merges single-cycle ALU results (no backpressure, highest priority) with
// buffered variable-latency load results into one registered write stream.
// Writes to register 0 are dropped, an ALU write kills older buffered loads
// to the same register, and decode is stalled while a source register still
// has a write in flight.
// Ports:
//   iClk, iReset_n              clock, async active-low reset
//   iAluValid/iAluReg/iAluData  ALU result
//   iLdValid/oLdReady           load handshake; iLdReg/iLdData payload
//   iChkReg1, iChkReg2          decode source registers
//   oStall                      read-after-write hazard (combinational)
//   oRegWr/oWrReg/oWrData       registered register-file write port
//   oPending                    buffered load count

module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = RF_ADDR_W
) (
  input  logic                   iClk,
  input  logic                   iReset_n,
  input  logic                   iAluValid,
  input  logic [AW-1:0]          iAluReg,
  input  logic [DATA_W-1:0]      iAluData,
  input  logic                   iLdValid,
  output logic                   oLdReady,
  input  logic [AW-1:0]          iLdReg,
  input  logic [DATA_W-1:0]      iLdData,
  input  logic [AW-1:0]          iChkReg1,
  input  logic [AW-1:0]          iChkReg2,
  output logic                   oStall,
  output logic                   oRegWr,
  output logic [AW-1:0]          oWrReg,
  output logic [DATA_W-1:0]      oWrData,
  output logic [$clog2(DEPTH):0] oPending
);

  logic                     aluWr_s;
  logic                     ldPush_s;
  logic                     ldPop_s;
  logic                     fifoFull_s;
  logic                     fifoEmpty_s;
  logic                     headValid_s;
  logic [AW-1:0]            headReg_s;
  logic [DATA_W-1:0]        headData_s;
  logic [DEPTH-1:0]         entValid_s;
  logic [DEPTH-1:0][AW-1:0] entReg_s;
  wbSrc_e                   srcSel_s;
  logic                     hit1_s;
  logic                     hit2_s;

  // A register-0 ALU result is no write at all, so it neither wins the port
  // nor kills anything.
  assign aluWr_s  = iAluValid && (iAluReg != {AW{1'b0}});
  // Ready looks only at the registered count: a same-cycle pop does not
  // make room.
  assign oLdReady = !fifoFull_s;
  // Register-0 loads complete the handshake but are never stored.
  assign ldPush_s = iLdValid && oLdReady && (iLdReg != {AW{1'b0}});
  // The head is retired whenever the ALU leaves the port free, even if the
  // entry was killed; that costs one idle write cycle.
  assign ldPop_s  = !aluWr_s && !fifoEmpty_s;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uFifo (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .iPush      (ldPush_s),
    .iPushReg   (iLdReg),
    .iPushData  (iLdData),
    .iPop       (ldPop_s),
    .iKill      (aluWr_s),
    .iKillReg   (iAluReg),
    .oFull      (fifoFull_s),
    .oEmpty     (fifoEmpty_s),
    .oCount     (oPending),
    .oHeadValid (headValid_s),
    .oHeadReg   (headReg_s),
    .oHeadData  (headData_s),
    .oEntValid  (entValid_s),
    .oEntReg    (entReg_s)
  );

  // Pick the write source for this cycle: ALU first, then a live head entry.
  always_comb begin
    srcSel_s = SRC_NONE;
    if (aluWr_s) begin
      srcSel_s = SRC_ALU;
    end else if (ldPop_s && headValid_s) begin
      srcSel_s = SRC_LOAD;
    end else begin
      srcSel_s = SRC_NONE;
    end
  end

  // Register-file write port register; address/data hold when idle.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oRegWr  <= 1'b0;
      oWrReg  <= {AW{1'b0}};
      oWrData <= {DATA_W{1'b0}};
    end else begin
      case (srcSel_s)
        SRC_ALU: begin
          oRegWr  <= 1'b1;
          oWrReg  <= iAluReg;
          oWrData <= iAluData;
        end
        SRC_LOAD: begin
          oRegWr  <= 1'b1;
          oWrReg  <= headReg_s;
          oWrData <= headData_s;
        end
        default: begin
          oRegWr  <= 1'b0;
        end
      endcase
    end
  end

  // Hazard detect: a source register is blocked by any live buffered entry
  // or by the write currently being presented to the register file.
  always_comb begin
    hit1_s = oRegWr & regHit(iChkReg1, oWrReg);
    hit2_s = oRegWr & regHit(iChkReg2, oWrReg);
    for (int i = 0; i < DEPTH; i++) begin
      hit1_s = hit1_s | (entValid_s[i] & regHit(iChkReg1, entReg_s[i]));
      hit2_s = hit2_s | (entValid_s[i] & regHit(iChkReg2, entReg_s[i]));
    end
    oStall = hit1_s | hit2_s;
  end

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: self-checking bench for wb_unit. A queue-based reference
// model predicts ready/pending/stall before each edge and the write port
// after it; directed scenarios are followed by a randomized phase.

module tb_wb_unit;
  import wb_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam int AW    = RF_ADDR_W;
  localparam int DW    = DATA_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          iClk = 1'b0;
  logic          iReset_n;
  logic          iAluValid;
  logic [AW-1:0] iAluReg;
  logic [DW-1:0] iAluData;
  logic          iLdValid;
  logic          oLdReady;
  logic [AW-1:0] iLdReg;
  logic [DW-1:0] iLdData;
  logic [AW-1:0] iChkReg1;
  logic [AW-1:0] iChkReg2;
  logic          oStall;
  logic          oRegWr;
  logic [AW-1:0] oWrReg;
  logic [DW-1:0] oWrData;
  logic [CW-1:0] oPending;

  wb_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iAluValid(iAluValid),
    .iAluReg  (iAluReg),
    .iAluData (iAluData),
    .iLdValid (iLdValid),
    .oLdReady (oLdReady),
    .iLdReg   (iLdReg),
    .iLdData  (iLdData),
    .iChkReg1 (iChkReg1),
    .iChkReg2 (iChkReg2),
    .oStall   (oStall),
    .oRegWr   (oRegWr),
    .oWrReg   (oWrReg),
    .oWrData  (oWrData),
    .oPending (oPending)
  );

  always #5 iClk = ~iClk;

  int nAssert = 0;
  int nFail   = 0;

  // Reference model: queued loads plus the expected write-port contents.
  bit            qV[$];
  logic [AW-1:0] qR[$];
  logic [DW-1:0] qD[$];
  bit            expWr;
  logic [AW-1:0] expReg;
  logic [DW-1:0] expData;
  // Register file as seen through the DUT write port.
  logic [DW-1:0] seenRf [2**AW];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelStall(input logic [AW-1:0] c);
    if (c == '0) return 1'b0;
    if (expWr && expReg == c) return 1'b1;
    foreach (qR[i]) if (qV[i] && qR[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    qV.delete(); qR.delete(); qD.delete();
    expWr = 1'b0; expReg = '0; expData = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model,
  // cross the edge, check the write port.
  task automatic step(input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      input bit lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld,
                      input logic [AW-1:0] c1, input logic [AW-1:0] c2, output bit acc);
    bit ready;
    iAluValid = av; iAluReg = ar; iAluData = ad;
    iLdValid = lv; iLdReg = lr; iLdData = ld;
    iChkReg1 = c1; iChkReg2 = c2;
    #2;
    ready = (qV.size() < DEPTH);
    chk("ldReady", 64'(oLdReady), 64'(ready));
    chk("pending", 64'(oPending), 64'(qV.size()));
    chk("stall", 64'(oStall), 64'(modelStall(c1) || modelStall(c2)));
    acc = lv && ready;
    if (av && ar != '0) begin
      expWr = 1'b1; expReg = ar; expData = ad;
      foreach (qR[i]) if (qR[i] == ar) qV[i] = 1'b0;
    end else if (qV.size() > 0) begin
      expWr = qV[0];
      if (qV[0]) begin expReg = qR[0]; expData = qD[0]; end
      void'(qV.pop_front()); void'(qR.pop_front()); void'(qD.pop_front());
    end else begin
      expWr = 1'b0;
    end
    if (acc && lr != '0) begin
      qV.push_back(1'b1); qR.push_back(lr); qD.push_back(ld);
    end
    @(posedge iClk); #1;
    chk("regWr", 64'(oRegWr), 64'(expWr));
    chk("wrReg", 64'(oWrReg), 64'(expReg));
    chk("wrData", 64'(oWrData), 64'(expData));
    if (oRegWr === 1'b1) seenRf[oWrReg] = oWrData;
  endtask

  task automatic idle(input logic [AW-1:0] c1);
    bit acc;
    step(1'b0, '0, '0, 1'b0, '0, '0, c1, '0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int idx;
    bit done;
    bit hold;
    logic [AW-1:0] hr, ar, c1, c2;
    logic [DW-1:0] hd, ad;
    bit av;

    foreach (seenRf[i]) seenRf[i] = '0;
    modelReset();
    iReset_n = 1'b0;
    iAluValid = 1'b0; iAluReg = '0; iAluData = '0;
    iLdValid = 1'b0; iLdReg = '0; iLdData = '0;
    iChkReg1 = '0; iChkReg2 = '0;
    #3;
    chk("rst.regWr", 64'(oRegWr), 64'd0);
    chk("rst.wrReg", 64'(oWrReg), 64'd0);
    chk("rst.wrData", 64'(oWrData), 64'd0);
    chk("rst.ldReady", 64'(oLdReady), 64'd1);
    chk("rst.stall", 64'(oStall), 64'd0);
    chk("rst.pending", 64'(oPending), 64'd0);
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    iReset_n = 1'b1;

    // ALU write reg 3
    step(1'b1, AW'(3), DW'(32'h1234), 1'b0, '0, '0, '0, '0, acc);
    chk("alu3.regWr", 64'(oRegWr), 64'd1);
    chk("alu3.wrReg", 64'(oWrReg), 64'd3);
    chk("alu3.wrData", 64'(oWrData), 64'h1234);
    idle('0);
    chk("alu3.after", 64'(oRegWr), 64'd0);

    // Single load reg 7, then stall while queued
    step(1'b0, '0, '0, 1'b1, AW'(7), DW'(32'hAA), AW'(7), '0, acc);
    chk("ld7.pending", 64'(oPending), 64'd1);
    iChkReg1 = AW'(7); #1;
    chk("ld7.stall", 64'(oStall), 64'd1);
    iChkReg1 = '0; #1;
    chk("ld7.nostall", 64'(oStall), 64'd0);
    idle(AW'(7));
    chk("ld7.regWr", 64'(oRegWr), 64'd1);
    chk("ld7.wrReg", 64'(oWrReg), 64'd7);
    chk("ld7.wrData", 64'(oWrData), 64'hAA);
    idle('0);

    // ALU busy while three loads are offered
    idx = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      step(cyc < 4, AW'(9), DW'($urandom), idx < 3, AW'(10 + idx), DW'(32'hB0 + idx),
           AW'(10), AW'(12), acc);
      if (acc) idx++;
      if (cyc == 3) begin
        chk("full.ldReady", 64'(oLdReady), 64'd0);
        chk("full.pending", 64'(oPending), 64'd2);
      end
      if (cyc >= 4 && idx == 3 && oPending == '0 && oRegWr == 1'b0) done = 1'b1;
    end
    chk("drain.timeout", 64'(done), 64'd1);
    chk("drain.ready", 64'(oLdReady), 64'd1);
    chk("drain.rf10", 64'(seenRf[10]), 64'hB0);
    chk("drain.rf11", 64'(seenRf[11]), 64'hB1);
    chk("drain.rf12", 64'(seenRf[12]), 64'hB2);

    // Kill: queued load reg 5 overtaken by ALU write reg 5
    seenRf[5] = '0;
    step(1'b0, '0, '0, 1'b1, AW'(5), DW'(32'h11), '0, '0, acc);
    step(1'b1, AW'(5), DW'(32'h22), 1'b0, '0, '0, AW'(5), '0, acc);
    chk("kill.regWr", 64'(oRegWr), 64'd1);
    chk("kill.wrData", 64'(oWrData), 64'h22);
    idle('0);
    chk("kill.popIdle", 64'(oRegWr), 64'd0);
    idle('0);
    chk("kill.rf5", 64'(seenRf[5]), 64'h22);
    chk("kill.pending", 64'(oPending), 64'd0);

    // Register 0 is never written
    step(1'b1, '0, DW'(32'h55), 1'b1, '0, DW'(32'h66), '0, '0, acc);
    chk("r0.regWr", 64'(oRegWr), 64'd0);
    chk("r0.pending", 64'(oPending), 64'd0);
    idle('0);
    chk("r0.regWr2", 64'(oRegWr), 64'd0);

    // Reset mid-drain
    step(1'b1, AW'(2), DW'(32'hC2), 1'b1, AW'(13), DW'(32'hD3), '0, '0, acc);
    step(1'b1, AW'(2), DW'(32'hC3), 1'b1, AW'(14), DW'(32'hD4), '0, '0, acc);
    idle('0);
    chk("mid.regWr", 64'(oRegWr), 64'd1);
    #2;
    iReset_n = 1'b0;
    #1;
    modelReset();
    chk("mid.rstRegWr", 64'(oRegWr), 64'd0);
    chk("mid.rstWrReg", 64'(oWrReg), 64'd0);
    chk("mid.rstWrData", 64'(oWrData), 64'd0);
    chk("mid.rstPending", 64'(oPending), 64'd0);
    chk("mid.rstReady", 64'(oLdReady), 64'd1);
    @(posedge iClk); #3;
    iReset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle(AW'(14));
      chk("mid.noWrite", 64'(oRegWr), 64'd0);
    end

    // Randomized traffic with small register range to provoke kills/hazards
    hold = 1'b0; hr = '0; hd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hold && $urandom_range(0, 99) < 60) begin
        hold = 1'b1;
        hr = AW'($urandom_range(0, 7));
        hd = DW'($urandom);
      end
      av = ($urandom_range(0, 99) < 50);
      ar = AW'($urandom_range(0, 7));
      ad = DW'($urandom);
      c1 = AW'($urandom_range(0, 7));
      c2 = AW'($urandom_range(0, 7));
      step(av, ar, ad, hold, hr, hd, c1, c2, acc);
      if (acc) hold = 1'b0;
    end
    for (int k = 0; k < 4; k++) idle('0);
    chk("final.pending", 64'(oPending), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
